// File: rtl/wrf_frame_checker.sv
// Fabric sink checking frame-ID sequence and payload pattern; ack one cycle after each accepted word.
// Backpressure: snk_stall_o is driven from a free-running LFSR while cyc is high (when enabled).
module wrf_frame_checker #(
  parameter bit          g_random_stall = 1'b1,
  parameter logic [15:0] g_lfsr_seed    = 16'hACE1,
  parameter int          g_max_payload  = 1500
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic [15:0] snk_dat_i,
  input  logic [1:0]  snk_adr_i,
  input  logic [1:0]  snk_sel_i,
  input  logic        snk_cyc_i,
  input  logic        snk_stb_i,
  input  logic        snk_we_i,
  output logic        snk_stall_o,
  output logic        snk_ack_o,
  output logic        snk_err_o,
  input  logic        clear_i,
  output logic [31:0] frames_ok_o,
  output logic [31:0] frames_lost_o,
  output logic [31:0] frames_bad_o,
  output logic [15:0] last_fid_o,
  output logic        frame_done_o
);

  typedef enum logic [2:0] {S_IDLE, S_STATUS, S_HDR, S_FID, S_PAYLOAD, S_OOB, S_DROP} state_t;

  localparam logic [15:0] MAX_PL = 16'(g_max_payload);

  state_t      state, state_eff, state_nxt;
  logic        cyc_d, drop_pend, skip_frame, bad;
  logic [15:0] lfsr, bcnt, fid, exp_fid;
  logic [2:0]  wcnt;

  logic        cyc_rise, cyc_fall, accept, wr, is_dat;
  logic        set_bad, ld_fid, hdr_inc;
  logic [1:0]  byte_add;
  logic [7:0]  b0, b1;
  logic        frame_bad;
  logic [15:0] d;
  logic [32:0] lost_sum;

  assign snk_err_o = 1'b0;
  assign cyc_rise  = snk_cyc_i & ~cyc_d;
  assign cyc_fall  = ~snk_cyc_i & cyc_d;
  assign accept    = snk_cyc_i & snk_stb_i & ~snk_stall_o;
  assign wr        = accept & snk_we_i;
  assign is_dat    = (snk_adr_i == 2'b00);

  // The word accepted on the cyc-rising cycle already belongs to the new frame.
  always_comb begin
    state_eff = state;
    if (state == S_IDLE && cyc_rise)
      state_eff = drop_pend ? S_DROP : S_STATUS;
  end

  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state_eff;
    if (cyc_fall) begin
      state_nxt = S_IDLE;
    end else if (wr) begin
      case (state_eff)
        S_STATUS:  state_nxt = (snk_adr_i == 2'b01) ? S_HDR : S_DROP;
        S_HDR:     if (is_dat && wcnt == 3'd6) state_nxt = S_FID;
        S_FID:     if (is_dat) state_nxt = S_PAYLOAD;
        S_PAYLOAD: if (snk_adr_i == 2'b10) state_nxt = S_OOB;
        default:   ;
      endcase
    end
  end

  always_comb begin
    set_bad  = 1'b0;
    byte_add = 2'd0;
    ld_fid   = 1'b0;
    hdr_inc  = 1'b0;
    b0       = bcnt[7:0];
    b1       = bcnt[7:0] + 8'd1;
    if (wr) begin
      case (state_eff)
        S_STATUS: set_bad = (snk_adr_i != 2'b01) | snk_dat_i[1];
        S_HDR:    hdr_inc = is_dat;
        S_FID:    ld_fid  = is_dat;
        S_PAYLOAD: begin
          if (is_dat) begin
            if (snk_sel_i == 2'b10) begin
              byte_add = 2'd1;
              set_bad  = (snk_dat_i[15:8] != b0);
            end else begin
              byte_add = 2'd2;
              set_bad  = (snk_dat_i[15:8] != b0) | (snk_dat_i[7:0] != b1);
            end
          end
        end
        S_OOB:    set_bad = is_dat;
        default:  ;
      endcase
    end
  end

  assign frame_bad = bad | ~(state == S_PAYLOAD || state == S_OOB) |
                     (bcnt < 16'd46) | (bcnt > MAX_PL);
  assign d        = fid - exp_fid;
  assign lost_sum = {1'b0, frames_lost_o} + {17'd0, d};

  always_ff @(posedge clk_sys or posedge rst_n) begin
    if (rst_n) begin
      cyc_d         <= 1'b0;
      lfsr          <= g_lfsr_seed;
      snk_stall_o   <= 1'b0;
      snk_ack_o     <= 1'b0;
      drop_pend     <= 1'b1;
      skip_frame    <= 1'b0;
      bad           <= 1'b0;
      wcnt          <= 3'd0;
      bcnt          <= 16'd0;
      fid           <= 16'd0;
      exp_fid       <= 16'd0;
      frames_ok_o   <= 32'd0;
      frames_lost_o <= 32'd0;
      frames_bad_o  <= 32'd0;
      last_fid_o    <= 16'd0;
      frame_done_o  <= 1'b0;
    end else begin
      cyc_d       <= snk_cyc_i;
      lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      snk_stall_o <= g_random_stall & snk_cyc_i & (lfsr[1:0] == 2'b00);
      snk_ack_o   <= accept;
      if (!snk_cyc_i) drop_pend <= 1'b0;

      if (state == S_IDLE && cyc_rise) begin
        skip_frame <= drop_pend;
        wcnt       <= 3'd0;
        bcnt       <= 16'd0;
        bad        <= 1'b0;
      end
      if (set_bad) bad  <= 1'b1;
      if (hdr_inc) wcnt <= wcnt + 3'd1;
      if (ld_fid) begin
        fid  <= {snk_dat_i[7:0], snk_dat_i[15:8]};
        bcnt <= 16'd2;
      end
      // Holding near the top keeps an absurdly long frame from wrapping back under the limit.
      if (byte_add != 2'd0 && bcnt < 16'hFFF0) bcnt <= bcnt + {14'd0, byte_add};

      frame_done_o <= 1'b0;
      if (cyc_fall && !skip_frame) begin
        frame_done_o <= 1'b1;
        if (!clear_i) begin
          if (frame_bad || d[15]) begin
            if (frames_bad_o != 32'hFFFF_FFFF) frames_bad_o <= frames_bad_o + 32'd1;
          end else begin
            if (frames_ok_o != 32'hFFFF_FFFF) frames_ok_o <= frames_ok_o + 32'd1;
            frames_lost_o <= lost_sum[32] ? 32'hFFFF_FFFF : lost_sum[31:0];
            exp_fid       <= fid + 16'd1;
            last_fid_o    <= fid;
          end
        end
      end
      if (clear_i) begin
        frames_ok_o   <= 32'd0;
        frames_lost_o <= 32'd0;
        frames_bad_o  <= 32'd0;
        exp_fid       <= 16'd0;
      end
    end
  end

endmodule

// File: tb/tb_wrf_frame_checker.sv
// Directed bench for wrf_frame_checker: builds fabric frames, drives them under random stall, checks counters.
module tb_wrf_frame_checker;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] snk_dat_i = 16'd0;
  logic [1:0]  snk_adr_i = 2'd0;
  logic [1:0]  snk_sel_i = 2'b11;
  logic        snk_cyc_i = 1'b0;
  logic        snk_stb_i = 1'b0;
  logic        snk_we_i = 1'b1;
  logic        snk_stall_o, snk_ack_o, snk_err_o;
  logic        clear_i = 1'b0;
  logic [31:0] frames_ok_o, frames_lost_o, frames_bad_o;
  logic [15:0] last_fid_o;
  logic        frame_done_o;

  wrf_frame_checker dut (
    .clk_sys(clk_sys), .rst_n(rst_n),
    .snk_dat_i(snk_dat_i), .snk_adr_i(snk_adr_i), .snk_sel_i(snk_sel_i),
    .snk_cyc_i(snk_cyc_i), .snk_stb_i(snk_stb_i), .snk_we_i(snk_we_i),
    .snk_stall_o(snk_stall_o), .snk_ack_o(snk_ack_o), .snk_err_o(snk_err_o),
    .clear_i(clear_i),
    .frames_ok_o(frames_ok_o), .frames_lost_o(frames_lost_o), .frames_bad_o(frames_bad_o),
    .last_fid_o(last_fid_o), .frame_done_o(frame_done_o)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [15:0] dat;
    logic [1:0]  adr;
    logic [1:0]  sel;
    logic        we;
  } word_t;

  word_t wq[$];
  int n_chk = 0;
  int n_bad = 0;
  int n_words = 0;
  int ack_cnt = 0;
  int ack_err = 0;
  int done_cnt = 0;
  logic acc_q = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, got, got, want, want);
    end
  endtask

  // Ack must follow every accepted word by exactly one cycle.
  always @(posedge clk_sys) acc_q <= rst_n ? 1'b0 : (snk_cyc_i & snk_stb_i & ~snk_stall_o);
  always @(negedge clk_sys) begin
    if (!rst_n) begin
      if (snk_ack_o) ack_cnt++;
      if (snk_ack_o !== acc_q) ack_err++;
      if (frame_done_o) done_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic build_frame(input logic [15:0] fid, input int plen, input logic st_err,
                             input int bad_idx, input bit extras);
    word_t w;
    logic [7:0] b0, b1;
    wq.delete();
    w.dat = {14'd0, st_err, 1'b0}; w.adr = 2'b01; w.sel = 2'b11; w.we = 1'b1;
    wq.push_back(w);
    for (int i = 0; i < 7; i++) begin
      w.dat = 16'hA500 + 16'(i); w.adr = 2'b00;
      wq.push_back(w);
    end
    w.dat = {fid[7:0], fid[15:8]};
    wq.push_back(w);
    for (int k = 2; k < plen; k += 2) begin
      b0 = (k == bad_idx) ? 8'h00 : 8'(k);
      b1 = (k + 1 == bad_idx) ? 8'h00 : 8'(k + 1);
      w.adr = 2'b00; w.we = 1'b1;
      if (k + 1 < plen) begin w.dat = {b0, b1};  w.sel = 2'b11; end
      else              begin w.dat = {b0, 8'h00}; w.sel = 2'b10; end
      wq.push_back(w);
      if (extras && k == 10) begin
        w.dat = 16'hFFFF; w.adr = 2'b11; w.sel = 2'b11; wq.push_back(w);
        w.dat = 16'h0000; w.adr = 2'b00; w.we = 1'b0;   wq.push_back(w);
      end
    end
    if (extras) begin
      w.dat = 16'h1234; w.adr = 2'b10; w.sel = 2'b11; w.we = 1'b1;
      wq.push_back(w);
    end
  endtask

  task automatic send_words(input int n);
    word_t w;
    for (int i = 0; i < n && wq.size() > 0; i++) begin
      w = wq.pop_front();
      snk_cyc_i = 1'b1; snk_stb_i = 1'b1;
      snk_dat_i = w.dat; snk_adr_i = w.adr; snk_sel_i = w.sel; snk_we_i = w.we;
      for (int t = 0; t < 100 && snk_stall_o; t++) begin
        @(posedge clk_sys); #1;
      end
      if (snk_stall_o) chk("stall_timeout", 32'(snk_stall_o), 32'd0);
      @(posedge clk_sys); #1;
      n_words++;
    end
    snk_stb_i = 1'b0;
  endtask

  task automatic end_frame(input bit with_clear);
    snk_cyc_i = 1'b0; snk_stb_i = 1'b0; clear_i = with_clear;
    @(posedge clk_sys); #1;
    clear_i = 1'b0;
    repeat (3) begin @(posedge clk_sys); #1; end
  endtask

  task automatic frame(input logic [15:0] fid, input int plen, input logic st_err,
                       input int bad_idx, input bit extras);
    build_frame(fid, plen, st_err, bad_idx, extras);
    send_words(100000);
    end_frame(1'b0);
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk_sys); #1;
    clear_i = 1'b0;
  endtask

  int plens[10] = '{60, 64, 99, 128, 257, 500, 777, 1000, 1499, 1500};

  initial begin
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_ok",    frames_ok_o, 32'd0);
    chk("rst_lost",  frames_lost_o, 32'd0);
    chk("rst_bad",   frames_bad_o, 32'd0);
    chk("rst_fid",   32'(last_fid_o), 32'd0);
    chk("rst_stall", 32'(snk_stall_o), 32'd0);
    chk("rst_ack",   32'(snk_ack_o), 32'd0);
    chk("rst_done",  32'(frame_done_o), 32'd0);
    chk("rst_err",   32'(snk_err_o), 32'd0);
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk_sys); #1; end

    // In-order IDs with varied lengths, odd tails, and ignored user/we=0/OOB words.
    for (int i = 0; i < 10; i++) frame(16'(i), plens[i], 1'b0, -1, (i == 3));
    chk("seq_ok",   frames_ok_o, 32'd10);
    chk("seq_lost", frames_lost_o, 32'd0);
    chk("seq_bad",  frames_bad_o, 32'd0);
    chk("seq_fid",  32'(last_fid_o), 32'd9);
    chk("seq_done", 32'(done_cnt), 32'd10);
    chk("seq_acks", 32'(ack_cnt), 32'(n_words));
    chk("ack_timing_errs", 32'(ack_err), 32'd0);

    do_clear();
    frame(16'd0, 60, 1'b0, -1, 1'b0);
    frame(16'd1, 60, 1'b0, -1, 1'b0);
    frame(16'd5, 60, 1'b0, -1, 1'b0);
    frame(16'd6, 60, 1'b0, -1, 1'b0);
    chk("gap_ok",   frames_ok_o, 32'd4);
    chk("gap_lost", frames_lost_o, 32'd3);
    chk("gap_bad",  frames_bad_o, 32'd0);
    chk("gap_fid",  32'(last_fid_o), 32'd6);

    do_clear();
    frame(16'd3, 60, 1'b0, -1, 1'b0);
    frame(16'd2, 60, 1'b0, -1, 1'b0);
    chk("ooo_bad", frames_bad_o, 32'd1);
    chk("ooo_ok",  frames_ok_o, 32'd1);
    chk("ooo_fid", 32'(last_fid_o), 32'd3);
    frame(16'd4, 60, 1'b0, -1, 1'b0);
    chk("ooo_next_ok",   frames_ok_o, 32'd2);
    chk("ooo_next_lost", frames_lost_o, 32'd3);

    do_clear();
    frame(16'd0, 200, 1'b0, 100, 1'b0);
    chk("corrupt_bad", frames_bad_o, 32'd1);
    chk("corrupt_ok",  frames_ok_o, 32'd0);
    frame(16'd0, 61, 1'b0, -1, 1'b0);
    chk("odd_ok",  frames_ok_o, 32'd1);
    chk("odd_fid", 32'(last_fid_o), 32'd0);
    frame(16'd1, 44, 1'b0, -1, 1'b0);
    chk("short_bad", frames_bad_o, 32'd2);
    frame(16'd1, 1502, 1'b0, -1, 1'b0);
    chk("long_bad", frames_bad_o, 32'd3);
    frame(16'd1, 46, 1'b0, -1, 1'b0);
    chk("min_ok",   frames_ok_o, 32'd2);
    chk("min_lost", frames_lost_o, 32'd0);

    do_clear();
    frame(16'h7FFF, 60, 1'b0, -1, 1'b0);
    frame(16'hFFFE, 60, 1'b0, -1, 1'b0);
    chk("wrap_pre_lost", frames_lost_o, 32'd65533);
    frame(16'hFFFF, 60, 1'b0, -1, 1'b0);
    frame(16'h0000, 60, 1'b0, -1, 1'b0);
    chk("wrap_ok",   frames_ok_o, 32'd4);
    chk("wrap_lost", frames_lost_o, 32'd65533);
    chk("wrap_fid",  32'(last_fid_o), 32'd0);
    frame(16'd1, 60, 1'b1, -1, 1'b0);
    chk("sterr_bad", frames_bad_o, 32'd1);
    chk("sterr_ok",  frames_ok_o, 32'd4);

    // Reset asserted mid-frame while cyc stays high: remainder must be ignored.
    build_frame(16'd0, 60, 1'b0, -1, 1'b0);
    send_words(12);
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk_sys); #1; end
    rst_n = 1'b0;
    send_words(100000);
    end_frame(1'b0);
    chk("rstmid_ok",   frames_ok_o, 32'd0);
    chk("rstmid_bad",  frames_bad_o, 32'd0);
    chk("rstmid_lost", frames_lost_o, 32'd0);
    frame(16'd0, 60, 1'b0, -1, 1'b0);
    chk("after_rst_ok", frames_ok_o, 32'd1);

    build_frame(16'd1, 60, 1'b0, -1, 1'b0);
    send_words(100000);
    end_frame(1'b1);
    chk("clr_ok",   frames_ok_o, 32'd0);
    chk("clr_lost", frames_lost_o, 32'd0);
    chk("clr_bad",  frames_bad_o, 32'd0);
    frame(16'd0, 60, 1'b0, -1, 1'b0);
    chk("post_clr_ok",   frames_ok_o, 32'd1);
    chk("post_clr_lost", frames_lost_o, 32'd0);
    chk("post_clr_bad",  frames_bad_o, 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
